// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller.
package sync_fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Storage address width for a given depth (at least one bit).
  function automatic int unsigned fifo_addr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_ram.sv
// DEPTH x D_WIDTH storage: synchronous write, asynchronous read.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [fifo_addr_w(DEPTH)-1:0] w_addr,
  input  logic [D_WIDTH-1:0]            w_data,
  input  logic [fifo_addr_w(DEPTH)-1:0] r_addr,
  output logic [D_WIDTH-1:0]            r_data
);

  logic [D_WIDTH-1:0] mem [DEPTH];

  // Write port; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data = mem[r_addr];

endmodule : sync_fifo_ram

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, occupancy, status flags, sticky errors and
// a mode-selectable read path (registered or first-word-fall-through).
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FWFT      = FIFO_MODE_STD,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [D_WIDTH-1:0]       w_data,
  input  logic                     rd_en,
  output logic [D_WIDTH-1:0]       r_data,
  output logic                     r_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int unsigned ADDR_W = fifo_addr_w(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] AF_T = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_T = CNT_W'(AE_THRESH);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               overflow_q;
  logic               underflow_q;
  logic               wr_ok;
  logic               rd_ok;
  logic [D_WIDTH-1:0] ram_rdata;

  // Flags come from registered state only, never from the request inputs.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                        (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign almost_full  = (count_q >= AF_T);
  assign almost_empty = (count_q <= AE_T);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // No pass-through: a full FIFO rejects writes, an empty one rejects reads.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  sync_fifo_ram #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (wr_ok && !rst),
    .w_addr (wr_ptr[ADDR_W-1:0]),
    .w_data (w_data),
    .r_addr (rd_ptr[ADDR_W-1:0]),
    .r_data (ram_rdata)
  );

  // Pointer and occupancy tracking; the wrap bit distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (clr_err) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      if (wr_en && full)  overflow_q  <= 1'b1;
      if (rd_en && empty) underflow_q <= 1'b1;
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head of queue is presented directly; rd_en acknowledges it.
      assign r_data  = ram_rdata;
      assign r_valid = !empty;
    end else begin : g_std
      logic [D_WIDTH-1:0] r_data_q;
      logic               r_valid_q;

      // One-cycle registered read; data holds between reads.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data_q  <= '0;
          r_valid_q <= 1'b0;
        end else begin
          r_valid_q <= rd_ok;
          if (rd_ok) r_data_q <= ram_rdata;
        end
      end

      assign r_data  = r_data_q;
      assign r_valid = r_valid_q;
    end
  endgenerate

endmodule : sync_fifo_ctrl

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl in standard and FWFT read modes.
module tb_sync_fifo_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Standard-mode instance signals
  logic          s_rst, s_wr, s_rd, s_clr;
  logic [DW-1:0] s_wd, s_rdata;
  logic          s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [4:0]    s_cnt;

  // FWFT-mode instance signals
  logic          f_rst, f_wr, f_rd, f_clr;
  logic [DW-1:0] f_wd, f_rdata;
  logic          f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0]    f_cnt;

  sync_fifo_ctrl #(.D_WIDTH(DW), .DEPTH(DP), .FWFT(0)) u_std (
    .clk(clk), .rst(s_rst), .wr_en(s_wr), .w_data(s_wd), .rd_en(s_rd),
    .r_data(s_rdata), .r_valid(s_rv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
    .overflow(s_ovf), .underflow(s_unf), .clr_err(s_clr)
  );

  sync_fifo_ctrl #(.D_WIDTH(DW), .DEPTH(DP), .FWFT(1)) u_fwft (
    .clk(clk), .rst(f_rst), .wr_en(f_wr), .w_data(f_wd), .rd_en(f_rd),
    .r_data(f_rdata), .r_valid(f_rv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(f_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_d;

  initial begin
    s_rst = 1'b1; s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0; s_wd = '0;
    f_rst = 1'b1; f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0; f_wd = '0;
    tick();
    tick();
    s_rst = 1'b0;
    f_rst = 1'b0;
    tick();

    // Reset / idle state
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_ae",    32'(s_ae),    32'd1);
    chk("rst_full",  32'(s_full),  32'd0);
    chk("rst_af",    32'(s_af),    32'd0);
    chk("rst_count", 32'(s_cnt),   32'd0);
    chk("rst_rv",    32'(s_rv),    32'd0);
    chk("rst_rdata", 32'(s_rdata), 32'd0);
    chk("rst_ovf",   32'(s_ovf),   32'd0);
    chk("rst_unf",   32'(s_unf),   32'd0);

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      s_wr = 1'b1;
      s_wd = DW'(i);
      tick();
      chk("fill_count", 32'(s_cnt), 32'(i));
      chk("fill_af",    32'(s_af),  32'(i >= 14));
      chk("fill_ae",    32'(s_ae),  32'(i <= 2));
    end
    chk("full_flag", 32'(s_full),  32'd1);
    chk("full_empty", 32'(s_empty), 32'd0);

    // 17th write dropped, overflow set
    s_wd = 8'h77;
    tick();
    chk("ovf_set",   32'(s_ovf), 32'd1);
    chk("ovf_count", 32'(s_cnt), 32'd16);
    s_wr = 1'b0;
    s_clr = 1'b1;
    tick();
    chk("ovf_clr", 32'(s_ovf), 32'd0);
    s_clr = 1'b0;

    // Drain in order, one-cycle latency
    for (int i = 1; i <= 16; i++) begin
      s_rd = 1'b1;
      tick();
      chk("drain_rv",    32'(s_rv),    32'd1);
      chk("drain_rdata", 32'(s_rdata), 32'(i));
    end
    chk("drain_empty", 32'(s_empty), 32'd1);
    chk("drain_count", 32'(s_cnt),   32'd0);

    // Extra read underflows, data holds
    tick();
    chk("unf_set",   32'(s_unf),   32'd1);
    chk("unf_rv",    32'(s_rv),    32'd0);
    chk("unf_rdata", 32'(s_rdata), 32'h10);
    s_rd = 1'b0;
    s_clr = 1'b1;
    tick();
    chk("unf_clr", 32'(s_unf), 32'd0);
    s_clr = 1'b0;

    // Preload 8 words
    for (int k = 0; k < 8; k++) begin
      s_wr = 1'b1;
      s_wd = DW'(8'h20 + k);
      q.push_back(s_wd);
      tick();
    end
    chk("pre_count", 32'(s_cnt), 32'd8);

    // 40 cycles of simultaneous write and read across pointer wrap
    for (int j = 0; j < 40; j++) begin
      s_wr = 1'b1;
      s_rd = 1'b1;
      s_wd = DW'(8'h28 + j);
      exp_d = q.pop_front();
      q.push_back(s_wd);
      tick();
      chk("wrap_count", 32'(s_cnt),   32'd8);
      chk("wrap_rdata", 32'(s_rdata), 32'(exp_d));
      chk("wrap_rv",    32'(s_rv),    32'd1);
    end

    // Drain the remaining 8
    s_wr = 1'b0;
    for (int j = 0; j < 8; j++) begin
      s_rd = 1'b1;
      exp_d = q.pop_front();
      tick();
      chk("tail_rdata", 32'(s_rdata), 32'(exp_d));
    end
    chk("tail_empty", 32'(s_empty), 32'd1);
    chk("tail_unf",   32'(s_unf),   32'd0);

    // Simultaneous write and read while empty
    s_wr = 1'b1;
    s_rd = 1'b1;
    s_wd = 8'h99;
    tick();
    chk("se_count", 32'(s_cnt), 32'd1);
    chk("se_unf",   32'(s_unf), 32'd1);
    chk("se_rv",    32'(s_rv),  32'd0);
    s_rd = 1'b0;

    // Grow to 5 entries
    for (int k = 0; k < 4; k++) begin
      s_wd = DW'(8'h40 + k);
      tick();
    end
    chk("mid_count", 32'(s_cnt), 32'd5);

    // Reset with write pending discards everything
    s_rst = 1'b1;
    s_wd = 8'h55;
    tick();
    chk("mr_count", 32'(s_cnt),   32'd0);
    chk("mr_empty", 32'(s_empty), 32'd1);
    chk("mr_unf",   32'(s_unf),   32'd0);
    s_rst = 1'b0;
    s_wr = 1'b0;
    s_rd = 1'b1;
    tick();
    chk("mr_rd_unf",   32'(s_unf),   32'd1);
    chk("mr_rd_rv",    32'(s_rv),    32'd0);
    chk("mr_rd_rdata", 32'(s_rdata), 32'd0);
    s_rd = 1'b0;

    // FWFT mode
    chk("fw_rst_rv",    32'(f_rv),    32'd0);
    chk("fw_rst_empty", 32'(f_empty), 32'd1);
    f_wr = 1'b1;
    f_wd = 8'hA5;
    tick();
    f_wr = 1'b0;
    chk("fw_rdata", 32'(f_rdata), 32'hA5);
    chk("fw_rv",    32'(f_rv),    32'd1);
    chk("fw_count", 32'(f_cnt),   32'd1);
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    chk("fw_pop_empty", 32'(f_empty), 32'd1);
    chk("fw_pop_rv",    32'(f_rv),    32'd0);

    f_wr = 1'b1;
    f_wd = 8'h11;
    tick();
    f_wd = 8'h22;
    tick();
    f_wr = 1'b0;
    chk("fw_head0", 32'(f_rdata), 32'h11);
    chk("fw_cnt2",  32'(f_cnt),   32'd2);
    f_rd = 1'b1;
    tick();
    chk("fw_head1", 32'(f_rdata), 32'h22);
    tick();
    f_rd = 1'b0;
    chk("fw_end_empty", 32'(f_empty), 32'd1);
    chk("fw_end_unf",   32'(f_unf),   32'd0);
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    chk("fw_unf", 32'(f_unf), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sync_fifo_ctrl
